// File: rtl/instruction_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : instruction_fetch_pkg
// Brief    : Shared constants, opcodes and FSM encoding for the fetch stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package instruction_fetch_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_RUN  = 2'd1;
    localparam fetch_state_t ST_HALT = 2'd2;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1:INSTR_W-6];
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_memory.sv
//------------------------------------------------------------------------------
// Module   : instruction_memory
// Brief    : IMEM_DEPTH x 32 program store, synchronous write, async read.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// Module   : instruction_fetch
// Brief    : Single-issue fetch stage with program load, stall, redirect, halt.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [INSTR_W-1:0]            load_data,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_target,
    output logic [INSTR_W-1:0]            instruction,
    output logic                          instr_valid,
    output logic [31:0]                   instr_pc,
    output logic [31:0]                   pc,
    output logic                          halted,
    output logic [15:0]                   issued_count
);

    localparam int C_ADDR_W = $clog2(IMEM_DEPTH);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_instruction;
    logic [31:0]        r_instr_pc;
    logic               r_instr_valid;
    logic [15:0]        r_issued_count;
    logic [INSTR_W-1:0] w_fetch_word;
    logic               w_load_we;
    logic               w_fetch_go;
    logic               w_fetch_halt;
    logic               w_halted;

    // Program loads only land while idle; a reset cycle never writes memory.
    assign w_load_we    = load_en && (r_state == ST_IDLE) && !rst;
    assign w_fetch_go   = (r_state == ST_RUN) && !redirect_valid && !stall;
    assign w_fetch_halt = (opcode_of(w_fetch_word) == OP_HALT);

    instruction_memory #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (C_ADDR_W)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_load_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (r_pc[C_ADDR_W-1:0]),
        .o_rdata (w_fetch_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (w_fetch_go && w_fetch_halt) w_next_state = ST_HALT;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_halted = (r_state == ST_HALT);
    end

    // Redirect outranks both stall and halt detection; the halt word is never issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_instruction  <= '0;
            r_instr_pc     <= '0;
            r_instr_valid  <= 1'b0;
            r_issued_count <= '0;
        end else if (r_state == ST_RUN) begin
            if (redirect_valid) begin
                r_pc          <= redirect_target;
                r_instr_valid <= 1'b0;
            end else if (!stall) begin
                if (w_fetch_halt) begin
                    r_instr_valid <= 1'b0;
                end else begin
                    r_instruction  <= w_fetch_word;
                    r_instr_pc     <= r_pc;
                    r_instr_valid  <= 1'b1;
                    r_pc           <= r_pc + 32'd1;
                    r_issued_count <= r_issued_count + 16'd1;
                end
            end
        end else begin
            r_instr_valid <= 1'b0;
        end
    end

    assign instruction  = r_instruction;
    assign instr_valid  = r_instr_valid;
    assign instr_pc     = r_instr_pc;
    assign pc           = r_pc;
    assign halted       = w_halted;
    assign issued_count = r_issued_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench: directed sequences, redirect table, random run.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        halted;
    logic [15:0] issued_count;

    int n_pass  = 0;
    int n_total = 0;

    instruction_fetch #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'd0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .start           (start),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .instr_pc        (instr_pc),
        .pc              (pc),
        .halted          (halted),
        .issued_count    (issued_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = idle, 1 = running, 2 = halted.
    logic [31:0] m_mem [DEPTH];
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid;
    logic [15:0] m_cnt;

    function automatic logic [31:0] pat(input int i);
        return 32'h0400_0000 | (i * 32'h0001_0101);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a[5:0];
        load_data = d;
        m_mem[a]  = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (load_en) m_mem[load_addr] = load_data;
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (redirect_valid) begin
                m_pc = redirect_target;
                m_valid = 0;
            end else if (!stall) begin
                w = m_mem[m_pc % DEPTH];
                if (w[31:26] == 6'h3F) begin
                    m_mode = 2;
                    m_valid = 0;
                end else begin
                    m_instr = w; m_ipc = m_pc; m_valid = 1;
                    m_pc = m_pc + 1; m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } rd_vec_t;

    rd_vec_t vecs [5];

    initial begin
        rst = 1; load_en = 0; load_addr = 0; load_data = 0;
        start = 0; stall = 0; redirect_valid = 0; redirect_target = 0;

        // Reset state
        tick(); tick();
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", {16'd0, issued_count}, 32'd0);
        rst = 0;

        // Three-word program ending in a halt word
        load_word(0, 32'h0C120024);
        load_word(1, 32'h000620C1);
        load_word(2, 32'hFC000000);
        start = 1; tick(); start = 0;
        chk("run_first_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("prog_i0", instruction, 32'h0C120024);
        chk("prog_ipc0", instr_pc, 32'd0);
        chk("prog_v0", {31'd0, instr_valid}, 32'd1);
        tick();
        chk("prog_i1", instruction, 32'h000620C1);
        chk("prog_ipc1", instr_pc, 32'd1);
        tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'd2);
        chk("halt_count", {16'd0, issued_count}, 32'd2);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);

        // Everything but reset is ignored in HALT, including loads
        load_en = 1; load_addr = 0; load_data = 32'hFC000000;
        start = 1; stall = 1; redirect_valid = 1; redirect_target = 7;
        tick(); tick();
        load_en = 0; start = 0; stall = 0; redirect_valid = 0;
        chk("haltq_halted", {31'd0, halted}, 32'd1);
        chk("haltq_pc", pc, 32'd2);
        chk("haltq_count", {16'd0, issued_count}, 32'd2);

        rst = 1; tick(); rst = 0;
        start = 1; tick(); start = 0; tick();
        chk("mem_kept_i0", instruction, 32'h0C120024);
        chk("mem_kept_cnt", {16'd0, issued_count}, 32'd1);

        // Full non-halting program for stall/redirect tests
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < DEPTH; i++) load_word(i, pat(i));
        start = 1; tick(); start = 0;
        repeat (4) tick();
        chk("pre_stall_ipc", instr_pc, 32'd3);
        for (int k = 0; k < 3; k++) begin
            stall = 1; tick();
            chk("stall_ipc", instr_pc, 32'd3);
            chk("stall_pc", pc, 32'd4);
            chk("stall_cnt", {16'd0, issued_count}, 32'd4);
            chk("stall_instr", instruction, pat(3));
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 0; tick();
        chk("resume_ipc", instr_pc, 32'd4);
        chk("resume_cnt", {16'd0, issued_count}, 32'd5);

        redirect_valid = 1; redirect_target = 21; stall = 1; tick();
        chk("rd_stall_valid", {31'd0, instr_valid}, 32'd0);
        chk("rd_stall_pc", pc, 32'd21);
        chk("rd_stall_cnt", {16'd0, issued_count}, 32'd5);
        redirect_valid = 0; stall = 0; tick();
        chk("rd_next_ipc", instr_pc, 32'd21);
        chk("rd_next_instr", instruction, pat(21));
        chk("rd_next_cnt", {16'd0, issued_count}, 32'd6);

        // Redirect table: index wrap and 32-bit pc wrap
        vecs[0] = '{32'd70,        pat(6),  32'd71};
        vecs[1] = '{32'd63,        pat(63), 32'd64};
        vecs[2] = '{32'd64,        pat(0),  32'd65};
        vecs[3] = '{32'hFFFF_FFFF, pat(63), 32'd0};
        vecs[4] = '{32'd145,       pat(17), 32'd146};
        for (int v = 0; v < 5; v++) begin
            redirect_valid = 1; redirect_target = vecs[v].target; tick();
            redirect_valid = 0; tick();
            chk($sformatf("tbl%0d_instr", v), instruction, vecs[v].exp_instr);
            chk($sformatf("tbl%0d_ipc", v), instr_pc, vecs[v].target);
            chk($sformatf("tbl%0d_pc", v), pc, vecs[v].exp_pc);
            chk($sformatf("tbl%0d_valid", v), {31'd0, instr_valid}, 32'd1);
        end

        // Reset mid-run at pc 9 with competing inputs
        redirect_valid = 1; redirect_target = 9; tick(); redirect_valid = 0;
        chk("pre_rst_pc", pc, 32'd9);
        rst = 1; start = 1; load_en = 1; load_addr = 0; load_data = 32'hFC000000;
        tick();
        rst = 0; start = 0; load_en = 0;
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_instr", instruction, 32'd0);
        chk("midrst_cnt", {16'd0, issued_count}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        start = 1; tick(); start = 0; tick();
        chk("midrst_i0", instruction, pat(0));
        chk("midrst_cnt1", {16'd0, issued_count}, 32'd1);

        // Halt word at 10 fetched during a redirect is not honoured
        rst = 1; tick(); rst = 0;
        load_word(10, 32'hFC000000);
        start = 1; tick(); start = 0;
        repeat (10) tick();
        chk("pre_hrd_pc", pc, 32'd10);
        redirect_valid = 1; redirect_target = 5; tick(); redirect_valid = 0;
        chk("hrd_halted", {31'd0, halted}, 32'd0);
        chk("hrd_pc", pc, 32'd5);
        repeat (6) tick();
        chk("hrd_late_halted", {31'd0, halted}, 32'd1);
        chk("hrd_late_pc", pc, 32'd10);
        chk("hrd_late_cnt", {16'd0, issued_count}, 32'd15);

        // Randomised run against the reference model
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < DEPTH; i++)
            load_word(i, ($urandom_range(0, 7) == 0) ? 32'hFC00_0000 | $urandom_range(0, 255)
                                                   : $urandom() & 32'hF7FF_FFFF);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 63) == 0);
            load_en         = ($urandom_range(0, 3) == 0);
            load_addr       = 6'($urandom_range(0, DEPTH - 1));
            load_data       = ($urandom_range(0, 7) == 0) ? 32'hFC00_0001 : $urandom();
            start           = ($urandom_range(0, 15) == 0);
            stall           = ($urandom_range(0, 3) == 0);
            redirect_valid  = ($urandom_range(0, 7) == 0);
            redirect_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                          : $urandom_range(0, 300);
            model_step();
            tick();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            chk("rnd_ipc", instr_pc, m_ipc);
            chk("rnd_instr", instruction, m_instr);
            chk("rnd_cnt", {16'd0, issued_count}, {16'd0, m_cnt});
            chk("rnd_halted", {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 64, meaning the number of 32-bit instruction words (power of two).
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the word address loaded into pc at reset.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port load_en, input, 1, writes one program word this cycle (IDLE only).
REQ-007 Port load_addr, input, log2(IMEM_DEPTH), word address of the program write.
REQ-008 Port load_data, input, 32, program word to write.
REQ-009 Port start, input, 1, single-cycle pulse that begins fetching.
REQ-010 Port stall, input, 1, downstream decode cannot accept; hold everything.
REQ-011 Port redirect_valid, input, 1, branch/jump taken; refetch from redirect_target.
REQ-012 Port redirect_target, input, 32, word address of the new fetch point.
REQ-013 Port instruction, output, 32, fetched word for the decode stage.
REQ-014 Port instr_valid, output, 1, instruction holds a live word.
REQ-015 Port instr_pc, output, 32, word address of the word on instruction.
REQ-016 Port pc, output, 32, address of the next word to fetch.
REQ-017 Port halted, output, 1, high while in HALT.
REQ-018 Port issued_count, output, 16, number of words issued with instr_valid since reset.

Function
REQ-019 FSM states SHALL be IDLE, RUN, HALT.
REQ-020 IDLE: load_en SHALL write load_data to imem[load_addr]; start SHALL move to RUN next cycle; load_en and start together SHALL perform the write and the transition.
REQ-021 load_en in RUN or HALT SHALL be ignored; start in RUN or HALT SHALL be ignored; only rst leaves HALT.
REQ-022 RUN, no stall, no redirect: instruction <= imem[pc mod IMEM_DEPTH], instr_pc <= pc, instr_valid <= 1, pc <= pc+1 (32-bit wrap), issued_count <= issued_count+1 (16-bit wrap); latency pc->instruction exactly 1 cycle.
REQ-023 RUN, stall=1, no redirect: pc, instruction, instr_pc, instr_valid, issued_count SHALL hold.
REQ-024 RUN, redirect_valid=1: pc <= redirect_target, instr_valid <= 0 (flush), issued_count holds; redirect SHALL win over stall and over halt detection.
REQ-025 pc addresses beyond IMEM_DEPTH SHALL wrap by using only the low log2(IMEM_DEPTH) bits for the memory index.
REQ-026 Halt: in RUN, no stall, no redirect, fetched word opcode bits[31:26]=6'b111111 -> state <= HALT, instr_valid <= 0, pc holds at the halt word's address, word not issued, issued_count holds.
REQ-027 HALT: instr_valid SHALL stay 0; pc, instr_pc, instruction, issued_count SHALL hold; stall and redirect ignored.
REQ-028 IDLE: instr_valid SHALL be 0 and stall/redirect ignored.

Reset
REQ-029 rst SHALL set state=IDLE, pc=RESET_PC, instruction=0, instr_pc=0, instr_valid=0, halted=0, issued_count=0, regardless of state or simultaneous inputs.
REQ-030 rst SHALL NOT clear instruction memory contents; a program loaded before reset mid-run SHALL be refetchable after start.

Structure
REQ-031 A shared package SHALL hold OP_RTYPE=6'b000000, OP_HALT=6'b111111, the FSM state encoding, and the instruction width 32.
REQ-032 Memory SHALL be one sub-module, instruction_memory: synchronous write, asynchronous read, IMEM_DEPTH x 32, no reset.

Verification
REQ-033 Load 0:32'h0C120024, 1:32'h000620C1, 2:32'hFC000000, start -> instruction 32'h0C120024 @instr_pc 0, then 32'h000620C1 @1, then halted=1, pc=2, issued_count=2.
REQ-034 Running word 3 with stall held 3 cycles -> instruction, instr_pc=3, pc=4, issued_count unchanged for 3 cycles, resume at 4.
REQ-035 redirect_valid=1, target=21, with stall=1 same cycle -> next cycle instr_valid=0, pc=21; following cycle instr_pc=21.
REQ-036 Redirect target 70 with IMEM_DEPTH 64 -> fetched word is imem[6], instr_pc=70.
REQ-037 Halt word fetched while redirect_valid=1 target 5 -> stays RUN, pc=5, halted=0.
REQ-038 rst asserted in RUN at pc=9, then start -> outputs at reset values, first issued word imem[0], issued_count=1, memory intact.
